// File: rtl/j1_io_responder_pkg.sv
// Shared I/O map for the j1 responder: address constants, STATUS bit positions and decode helper.
// The core and the firmware header use the same values.
package j1_io_responder_pkg;

    localparam logic [15:0] IO_LEDS   = 16'h0001;
    localparam logic [15:0] IO_TICKS  = 16'h0002;
    localparam logic [15:0] IO_TX     = 16'h1000;
    localparam logic [15:0] IO_STATUS = 16'h2000;
    localparam logic [15:0] IO_ADC    = 16'h2001;

    localparam int ST_TX_EMPTY  = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_TX_OVF    = 2;
    localparam int ST_ADC_VALID = 3;
    localparam int ST_ADC_OVF   = 4;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_LEDS,
        SEL_TICKS,
        SEL_TX,
        SEL_STATUS,
        SEL_ADC
    } io_sel_t;

    // Full 16-bit compare; anything else is unmapped.
    function automatic io_sel_t io_decode(input logic [15:0] addr);
        case (addr)
            IO_LEDS:   return SEL_LEDS;
            IO_TICKS:  return SEL_TICKS;
            IO_TX:     return SEL_TX;
            IO_STATUS: return SEL_STATUS;
            IO_ADC:    return SEL_ADC;
            default:   return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a registered head word.
// A push into an empty FIFO shows up at the head one cycle later (no fall-through).
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_next;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_next = rd_ptr + {{AW{1'b0}}, do_pop};

    // Head for the next cycle: the word being written if it lands in the head slot.
    always_comb begin
        head_next = mem[rd_next[AW-1:0]];
        if (do_push && (rd_next[AW-1:0] == wr_ptr[AW-1:0])) begin
            head_next = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            rd_ptr  <= rd_next;
            rd_data <= head_next;
        end
    end

endmodule

// File: rtl/j1_io_responder.sv
// Target-side I/O responder for the j1 core: LEDs, tick counter, TX byte FIFO and ADC latch.
// Reads are a mux of the previous-cycle address and current register state.
module j1_io_responder
    import j1_io_responder_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int TX_DEPTH = 8,
    parameter int ADC_BITS = 12
) (
    input  logic                clk,
    input  logic                resetq,
    input  logic                io_wr,
    input  logic [15:0]         mem_addr,
    input  logic [WIDTH-1:0]    dout,
    output logic [WIDTH-1:0]    io_din,
    output logic [7:0]          leds,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic                adc_strobe,
    input  logic [ADC_BITS-1:0] adc_sample
);

    logic [15:0]         addr_q;
    logic [15:0]         ticks;
    logic [ADC_BITS-1:0] sample;
    logic                tx_ovf;
    logic                adc_valid;
    logic                adc_ovf;
    logic                tx_full;
    logic                tx_empty;
    logic                tx_push;
    logic                tx_pop;
    logic                adc_clear;
    logic                status_wr;
    logic                unused_dout;
    io_sel_t             wr_sel;
    io_sel_t             rd_sel;

    assign wr_sel      = io_wr ? io_decode(mem_addr) : SEL_NONE;
    assign rd_sel      = io_decode(addr_q);
    assign tx_push     = (wr_sel == SEL_TX);
    assign adc_clear   = (wr_sel == SEL_ADC);
    assign status_wr   = (wr_sel == SEL_STATUS);
    assign tx_valid    = !tx_empty;
    assign tx_pop      = tx_valid && tx_ready;
    assign unused_dout = ^dout[WIDTH-1:8];

    io_sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .resetq  (resetq),
        .push    (tx_push),
        .wr_data (dout[7:0]),
        .pop     (tx_pop),
        .rd_data (tx_data),
        .empty   (tx_empty),
        .full    (tx_full)
    );

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            addr_q    <= '0;
            leds      <= '0;
            ticks     <= '0;
            tx_ovf    <= 1'b0;
            adc_valid <= 1'b0;
            adc_ovf   <= 1'b0;
            sample    <= '0;
        end else begin
            addr_q <= mem_addr;

            if (wr_sel == SEL_LEDS) begin
                leds <= dout[7:0];
            end

            if (wr_sel == SEL_TICKS) begin
                ticks <= '0;
            end else begin
                ticks <= ticks + 16'd1;
            end

            // A new overflow event beats a clear arriving in the same cycle.
            if (tx_push && tx_full) begin
                tx_ovf <= 1'b1;
            end else if (status_wr && dout[ST_TX_OVF]) begin
                tx_ovf <= 1'b0;
            end

            if (adc_strobe && adc_valid && !adc_clear) begin
                adc_ovf <= 1'b1;
            end else if (status_wr && dout[ST_ADC_OVF]) begin
                adc_ovf <= 1'b0;
            end

            if (adc_strobe) begin
                sample    <= adc_sample;
                adc_valid <= 1'b1;
            end else if (adc_clear) begin
                adc_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        io_din = '0;
        case (rd_sel)
            SEL_LEDS:  io_din[7:0] = leds;
            SEL_TICKS: io_din[15:0] = ticks;
            SEL_STATUS: begin
                io_din[ST_TX_EMPTY]  = tx_empty;
                io_din[ST_TX_FULL]   = tx_full;
                io_din[ST_TX_OVF]    = tx_ovf;
                io_din[ST_ADC_VALID] = adc_valid;
                io_din[ST_ADC_OVF]   = adc_ovf;
            end
            SEL_ADC:   io_din[ADC_BITS-1:0] = sample;
            default:   io_din = '0;
        endcase
    end

endmodule
